// File: rtl/longlat_pkg.sv
// Shared types and constants for the long-latency writeback scheduler slice.
// Register indices, datapath width and the starvation FSM encoding live here.
package longlat_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 1 << REG_IDX_W;

  typedef logic [REG_IDX_W-1:0] regIdx_t;
  typedef logic [XLEN-1:0]      xlen_t;

  localparam regIdx_t X0 = '0;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } llState_e;

  function automatic logic isX0(input regIdx_t idx);
    return idx == X0;
  endfunction

endpackage

// File: rtl/longlat_wb_scheduler_if.sv
// Bundle of decode, issue, completion, pipeline-writeback and register-file
// signals around the scheduler. The scheduler binds to the slave modport.
interface longlat_wb_scheduler_if #(
  parameter int MAX_OUTSTANDING = 4
);
  import longlat_pkg::*;

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Handshakes: a transfer happens in a cycle where valid && ready are both
  // high at the clock edge; ready never depends on valid except for
  // cpl_ready, which is by definition qualified by cpl_valid. A presented
  // completion keeps its payload stable and stays valid until it transfers.
  logic     iss_valid;
  logic     iss_ready;
  regIdx_t  iss_rd;
  logic     iss_fp;

  regIdx_t  dec_rs1;
  regIdx_t  dec_rs2;
  regIdx_t  dec_rd;
  logic     dec_rs1_fp;
  logic     dec_rs2_fp;
  logic     dec_rd_fp;
  logic     dec_use_rs1;
  logic     dec_use_rs2;
  logic     dec_use_rd;
  logic     hazard_stall;

  logic     RegWriteW;
  regIdx_t  RD_W;
  xlen_t    ResultW;
  logic     FPRegWriteW;
  regIdx_t  FP_RD_W;
  xlen_t    FP_ResultW;

  logic     cpl_valid;
  logic     cpl_ready;
  regIdx_t  cpl_rd;
  logic     cpl_fp;
  xlen_t    cpl_data;

  logic     rf_we;
  regIdx_t  rf_wa;
  xlen_t    rf_wd;
  logic     fprf_we;
  regIdx_t  fprf_wa;
  xlen_t    fprf_wd;

  logic             wb_stall;
  logic [CNT_W-1:0] outstanding;
  llState_e         dbgState;

  modport master (
    output iss_valid, iss_rd, iss_fp,
    output dec_rs1, dec_rs2, dec_rd, dec_rs1_fp, dec_rs2_fp, dec_rd_fp,
    output dec_use_rs1, dec_use_rs2, dec_use_rd,
    output RegWriteW, RD_W, ResultW, FPRegWriteW, FP_RD_W, FP_ResultW,
    output cpl_valid, cpl_rd, cpl_fp, cpl_data,
    input  iss_ready, hazard_stall, cpl_ready,
    input  rf_we, rf_wa, rf_wd, fprf_we, fprf_wa, fprf_wd,
    input  wb_stall, outstanding, dbgState
  );

  modport slave (
    input  iss_valid, iss_rd, iss_fp,
    input  dec_rs1, dec_rs2, dec_rd, dec_rs1_fp, dec_rs2_fp, dec_rd_fp,
    input  dec_use_rs1, dec_use_rs2, dec_use_rd,
    input  RegWriteW, RD_W, ResultW, FPRegWriteW, FP_RD_W, FP_ResultW,
    input  cpl_valid, cpl_rd, cpl_fp, cpl_data,
    output iss_ready, hazard_stall, cpl_ready,
    output rf_we, rf_wa, rf_wd, fprf_we, fprf_wa, fprf_wd,
    output wb_stall, outstanding, dbgState
  );

endinterface

// File: rtl/busy_scoreboard.sv
// Per-register busy bits for one register file: one set port (issue), one
// clear port (completion) and three combinational lookups for decode.
module busy_scoreboard
  import longlat_pkg::*;
#(
  parameter bit MASK_X0 = 1'b0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            setEn,
  input  regIdx_t                         setIdx,
  input  logic                            clrEn,
  input  regIdx_t                         clrIdx,
  input  logic [2:0][REG_IDX_W-1:0]       lookIdx,
  output logic [2:0]                      lookHit,
  output logic [NUM_REGS-1:0]             busyVec
);

  logic [NUM_REGS-1:0] busy;

  // Issue cannot target a busy register, so set and clear never hit the
  // same bit in one cycle; ordering them here is only for readability.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (clrEn) begin
        busy[clrIdx] <= 1'b0;
      end
      if (setEn && !(MASK_X0 && isX0(setIdx))) begin
        busy[setIdx] <= 1'b1;
      end
    end
  end

  always_comb begin
    lookHit = '0;
    for (int i = 0; i < 3; i++) begin
      lookHit[i] = busy[lookIdx[i]] && !(MASK_X0 && isX0(lookIdx[i]));
    end
  end

  assign busyVec = busy;

endmodule

// File: rtl/longlat_wb_scheduler.sv
// Merges long-latency results into the integer/FP write ports behind the
// in-order pipeline, tracks outstanding destinations and stalls decode.
module longlat_wb_scheduler
  import longlat_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  longlat_wb_scheduler_if.slave bus
);

  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int WAIT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARVE_LIMIT - 1);

  logic [NUM_REGS-1:0]        intBusy;
  logic [NUM_REGS-1:0]        fpBusy;
  logic [2:0]                 intHit;
  logic [2:0]                 fpHit;
  logic [2:0][REG_IDX_W-1:0]  lookIdx;
  logic [2:0]                 lookFp;
  logic [2:0]                 lookUse;

  logic              issReady;
  logic              issFire;
  logic              cplReady;
  logic              cplFire;
  logic              cplBlocked;
  logic              cplIntFire;
  logic              cplFpFire;
  logic              hazard;

  logic [CNT_W-1:0]  outstandingQ;
  logic [WAIT_W-1:0] waitCnt;
  logic              wbStallQ;
  llState_e          state;

  // Lookup slot 0 = rs1, 1 = rs2, 2 = rd in both scoreboards.
  assign lookIdx = {bus.dec_rd, bus.dec_rs2, bus.dec_rs1};
  assign lookFp  = {bus.dec_rd_fp, bus.dec_rs2_fp, bus.dec_rs1_fp};
  assign lookUse = {bus.dec_use_rd, bus.dec_use_rs2, bus.dec_use_rs1};

  always_comb begin
    issReady = (outstandingQ < MAX_CNT) &&
               !(bus.iss_fp ? fpBusy[bus.iss_rd] : intBusy[bus.iss_rd]);
  end

  // The pipeline owns each write port first; a completion only needs the
  // port of its own file to be free.
  always_comb begin
    cplReady = bus.cpl_valid &&
               (bus.cpl_fp ? !bus.FPRegWriteW : !bus.RegWriteW);
  end

  assign issFire    = bus.iss_valid && issReady;
  assign cplFire    = cplReady;
  assign cplBlocked = bus.cpl_valid && !cplReady;
  assign cplIntFire = cplFire && !bus.cpl_fp;
  assign cplFpFire  = cplFire && bus.cpl_fp;

  busy_scoreboard #(.MASK_X0(1'b1)) u_int_sb (
    .clk     (clk),
    .rst     (rst),
    .setEn   (issFire && !bus.iss_fp),
    .setIdx  (bus.iss_rd),
    .clrEn   (cplIntFire),
    .clrIdx  (bus.cpl_rd),
    .lookIdx (lookIdx),
    .lookHit (intHit),
    .busyVec (intBusy)
  );

  busy_scoreboard #(.MASK_X0(1'b0)) u_fp_sb (
    .clk     (clk),
    .rst     (rst),
    .setEn   (issFire && bus.iss_fp),
    .setIdx  (bus.iss_rd),
    .clrEn   (cplFpFire),
    .clrIdx  (bus.cpl_rd),
    .lookIdx (lookIdx),
    .lookHit (fpHit),
    .busyVec (fpBusy)
  );

  // Busy clears on the edge after the completion write, so decode still
  // stalls during the write cycle and reads the file afterwards: no bypass.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (lookUse[i] && (lookFp[i] ? fpHit[i] : intHit[i])) begin
        hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstandingQ <= '0;
    end else begin
      case ({issFire, cplFire})
        2'b10:   outstandingQ <= outstandingQ + 1'b1;
        2'b01:   outstandingQ <= outstandingQ - 1'b1;
        default: outstandingQ <= outstandingQ;
      endcase
    end
  end

  // Starvation: after STARVE_LIMIT blocked cycles ask the pipeline for a W
  // bubble and hold the request until the stuck result gets through.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      waitCnt  <= '0;
      wbStallQ <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cplBlocked) begin
            if (waitCnt == WAIT_LAST) begin
              state    <= DRAIN;
              wbStallQ <= 1'b1;
              waitCnt  <= '0;
            end else begin
              waitCnt  <= waitCnt + 1'b1;
            end
          end else begin
            waitCnt <= '0;
          end
        end
        DRAIN: begin
          if (cplFire || !bus.cpl_valid) begin
            state    <= IDLE;
            wbStallQ <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          wbStallQ <= 1'b0;
          waitCnt  <= '0;
        end
      endcase
    end
  end

  assign bus.iss_ready    = issReady;
  assign bus.cpl_ready    = cplReady;
  assign bus.hazard_stall = hazard;

  assign bus.rf_we   = bus.RegWriteW || (cplIntFire && !isX0(bus.cpl_rd));
  assign bus.rf_wa   = cplIntFire ? bus.cpl_rd   : bus.RD_W;
  assign bus.rf_wd   = cplIntFire ? bus.cpl_data : bus.ResultW;
  assign bus.fprf_we = bus.FPRegWriteW || cplFpFire;
  assign bus.fprf_wa = cplFpFire ? bus.cpl_rd   : bus.FP_RD_W;
  assign bus.fprf_wd = cplFpFire ? bus.cpl_data : bus.FP_ResultW;

  assign bus.wb_stall    = wbStallQ;
  assign bus.outstanding = outstandingQ;
  assign bus.dbgState    = state;

endmodule

// File: doc/longlat_wb_scheduler.md
Name: longlat_wb_scheduler

Overview:
Sequences long-latency results (integer DIV/REM, FP DIV/SQRT) into the integer and FP register-file write ports. Both ports are shared with the in-order pipeline writeback. Keeps a per-register busy scoreboard for both files and stalls decode on RAW/WAW hazards against outstanding long-latency destinations. Sits between decode, the long-latency unit and the two register files.

Parameters:
MAX_OUTSTANDING, 4, maximum issued-but-not-completed long-latency ops
STARVE_LIMIT, 8, consecutive blocked-completion cycles before a forced writeback bubble is requested

Ports:
clk  in  1  clock
rst  in  1  reset
iss_valid  in  1  decode issues a long-latency op
iss_ready  out  1  issue accepted
iss_rd  in  5  destination register
iss_fp  in  1  destination is in the FP file
dec_rs1, dec_rs2, dec_rd  in  5 each  decode operand/destination indices
dec_rs1_fp, dec_rs2_fp, dec_rd_fp  in  1 each  operand is in the FP file
dec_use_rs1, dec_use_rs2, dec_use_rd  in  1 each  field is meaningful
hazard_stall  out  1  hold decode
RegWriteW, RD_W, ResultW  in  1/5/32  pipeline integer writeback
FPRegWriteW, FP_RD_W, FP_ResultW  in  1/5/32  pipeline FP writeback
cpl_valid  in  1  long-latency result available
cpl_ready  out  1  result accepted this cycle
cpl_rd  in  5  result destination
cpl_fp  in  1  result targets the FP file
cpl_data  in  32  result value
rf_we, rf_wa, rf_wd  out  1/5/32  integer register-file write port
fprf_we, fprf_wa, fprf_wd  out  1/5/32  FP register-file write port
wb_stall  out  1  request a bubble in the W stage
outstanding  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count

Behaviour:
- Clocking and reset: single clock, posedge clk. Reset is synchronous and active-high on rst.
- Reset state: busy_int=0, busy_fp=0, outstanding=0, wait_cnt=0, state=IDLE, wb_stall=0. Resulting combinational outputs: iss_ready=1, hazard_stall=0.
- Reset mid-operation discards all pending ops. The long-latency unit shares rst.
- Issue:
  - iss_ready = (outstanding < MAX_OUTSTANDING) && !busy[iss_fp][iss_rd].
  - iss_ready is independent of iss_valid.
  - On fire, set busy[iss_fp][iss_rd] at the next edge. Integer x0 is never set.
  - The busy check blocks a same-register issue, so set and clear of one register never collide in a cycle.
- outstanding: +1 on issue fire, −1 on completion fire, unchanged when both fire.
- hazard_stall (combinational from registered busy):
  - Asserted when any used field hits a busy bit in its own file. Integer x0 is never a hit.
  - Remains high during the cycle the completion writes. It drops the cycle after, so no bypass is required.
- Write ports:
  - Pipeline writes pass through unchanged: rf_we=RegWriteW, rf_wa=RD_W, rf_wd=ResultW. FP port likewise.
  - cpl_ready = cpl_valid && (cpl_fp ? !FPRegWriteW : !RegWriteW). The pipeline always has priority.
  - On completion fire, the selected port is driven with cpl_rd/cpl_data, and the busy bit is cleared at the next edge.
  - An integer completion to x0 fires but holds rf_we=0.
- Completion handshake: cpl_rd, cpl_fp and cpl_data are stable while cpl_valid && !cpl_ready. cpl_valid is not withdrawn before fire.
- Starvation FSM:
  - IDLE: wait_cnt increments on every cycle with cpl_valid && !cpl_ready, and clears on fire or !cpl_valid.
  - When wait_cnt reaches STARVE_LIMIT−1 and the result is still blocked, go to DRAIN. wb_stall is registered high from the next cycle.
  - DRAIN: wb_stall=1. The pipeline injects a W bubble. On completion fire, return to IDLE; wb_stall drops the following cycle. If cpl_valid is low (protocol violation), return to IDLE.
- Simultaneous issue and completion are legal, including to different files in the same cycle.
- A completion to one file never blocks on pipeline activity in the other file.

Decomposition:
- Package longlat_pkg: state enum {IDLE, DRAIN}, REG_IDX_W=5, XLEN=32, X0 constant.
- Sub-module busy_scoreboard:
  - One 32-bit busy vector per file with set, clear and three lookup ports, plus an x0-mask parameter.
  - Instantiated twice (integer with x0 mask, FP without).

Test Plan:
- Reset, issue int rd=5, complete with data 0x1234 while RegWriteW=0 -> rf_we=1, rf_wa=5, rf_wd=0x1234 in the completion cycle; busy_int[5] clear next cycle; outstanding 1→0.
- Issue fp rd=3, decode fp rs1=3 -> hazard_stall=1 until the cycle after completion; int rs1=3 -> hazard_stall=0.
- Fill 4 ops (rd 1–4) -> iss_ready=0; one completion -> iss_ready=1 next cycle; issue rd=2 while busy -> iss_ready=0.
- RegWriteW=1 for 8 consecutive cycles with an int completion pending -> wb_stall=1 from cycle 9; RegWriteW=0 -> fire, wb_stall=0 the next cycle.
- Int completion pending with RegWriteW=1, FP completion path -> FP completion fires regardless; integer path waits.
- rst asserted with 3 outstanding -> next cycle outstanding=0, busy all clear, wb_stall=0, iss_ready=1.
